// File: rtl/post_adder_carryout.sv
// post_adder_carryout: 48-bit post-adder/subtractor with carry-out.
// Selects X and Z from OPMODE, forms Z +/- (X + CIN) in 49 bits, and keeps
// the result in an accumulator that drives P, PCOUT and the P feedback path.
module post_adder_carryout #(
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CEP,
  input  logic        CECARRYIN,
  input  logic [7:0]  OPMODE,
  input  logic [35:0] M,
  input  logic [17:0] D,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic        CIN,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  localparam int DATA_W = 48;

  logic [DATA_W-1:0] x_sel;
  logic [DATA_W-1:0] z_sel;
  logic [DATA_W:0]   sum_p0;
  logic [DATA_W-1:0] acc_p1;
  logic              cyo_p1;

  // OPMODE[6:4] and D[17:12] have no function in this slice.
  logic unused_bits;
  assign unused_bits = ^{OPMODE[6:4], D[17:12]};

  // Zero-extended 49-bit add or subtract; bit 48 is carry (add) or borrow (sub).
  function automatic logic [DATA_W:0] post_add(
    input logic [DATA_W-1:0] z,
    input logic [DATA_W-1:0] x,
    input logic              cin,
    input logic              sub
  );
    logic [DATA_W:0] ze;
    logic [DATA_W:0] xe;
    logic [DATA_W:0] ce;
    ze = {1'b0, z};
    xe = {1'b0, x};
    ce = {{DATA_W{1'b0}}, cin};
    if (sub) post_add = ze - xe - ce;
    else     post_add = ze + xe + ce;
  endfunction

  // Stage p0: operand selection; feedback always comes from the registered acc.
  always_comb begin
    x_sel = '0;
    case (OPMODE[1:0])
      2'd0:    x_sel = '0;
      2'd1:    x_sel = {12'b0, M};
      2'd2:    x_sel = acc_p1;
      default: x_sel = {D[11:0], A, B};
    endcase
  end

  // Z operand selection.
  always_comb begin
    z_sel = '0;
    case (OPMODE[3:2])
      2'd0:    z_sel = '0;
      2'd1:    z_sel = PCIN;
      2'd2:    z_sel = acc_p1;
      default: z_sel = C;
    endcase
  end

  assign sum_p0 = post_add(z_sel, x_sel, CIN, OPMODE[7]);

  // Stage p1: accumulator register, wraps modulo 2^48.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      acc_p1 <= '0;
    else if (CEP) acc_p1 <= sum_p0[DATA_W-1:0];
  end

  // Carry/borrow register, enabled independently of the accumulator.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            cyo_p1 <= 1'b0;
    else if (CECARRYIN) cyo_p1 <= sum_p0[DATA_W];
  end

  generate
    if (PREG == 1) begin : g_p_reg
      assign P = acc_p1;
    end else begin : g_p_comb
      assign P = sum_p0[DATA_W-1:0];
    end
    if (CARRYOUTREG == 1) begin : g_cy_reg
      assign CARRYOUT = cyo_p1;
    end else begin : g_cy_comb
      assign CARRYOUT = sum_p0[DATA_W];
    end
  endgenerate

  assign PCOUT     = acc_p1;
  assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_post_adder_carryout.sv
// Directed bench for post_adder_carryout: one registered instance
// (PREG=1, CARRYOUTREG=1) and one combinational instance (PREG=0,
// CARRYOUTREG=0) share the same stimulus.
module tb_post_adder_carryout;

  logic        clk = 1'b0;
  logic        rst;
  logic        cep;
  logic        cecarryin;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [17:0] d;
  logic [17:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic [47:0] pcin;
  logic        cin;

  logic [47:0] r_p, r_pcout, k_p, k_pcout;
  logic        r_cy, r_cyf, k_cy, k_cyf;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  post_adder_carryout #(.PREG(1), .CARRYOUTREG(1)) dut_reg (
    .CLK(clk), .RST(rst), .CEP(cep), .CECARRYIN(cecarryin), .OPMODE(opmode),
    .M(m), .D(d), .A(a), .B(b), .C(c), .PCIN(pcin), .CIN(cin),
    .P(r_p), .PCOUT(r_pcout), .CARRYOUT(r_cy), .CARRYOUTF(r_cyf)
  );

  post_adder_carryout #(.PREG(0), .CARRYOUTREG(0)) dut_comb (
    .CLK(clk), .RST(rst), .CEP(cep), .CECARRYIN(cecarryin), .OPMODE(opmode),
    .M(m), .D(d), .A(a), .B(b), .C(c), .PCIN(pcin), .CIN(cin),
    .P(k_p), .PCOUT(k_pcout), .CARRYOUT(k_cy), .CARRYOUTF(k_cyf)
  );

  task automatic test_reset();
    #2;
    vectors++; if (r_p !== 48'h0) begin miscompares++; $display("FAIL rst_p: got %h want 0", r_p); end
    vectors++; if (r_pcout !== 48'h0) begin miscompares++; $display("FAIL rst_pcout: got %h want 0", r_pcout); end
    vectors++; if (r_cy !== 1'b0 || r_cyf !== 1'b0) begin miscompares++; $display("FAIL rst_cy: got %b/%b want 0/0", r_cy, r_cyf); end
    vectors++; if (k_pcout !== 48'h0) begin miscompares++; $display("FAIL rst_comb_pcout: got %h want 0", k_pcout); end
    @(negedge clk);
    rst = 1'b0;
    opmode = 8'h0D; c = 48'hFFFF_FFFF_FFFF; m = 36'd2; cin = 1'b0;
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'h1 || r_cy !== 1'b1) begin miscompares++; $display("FAIL preload: got p=%h cy=%b want p=1 cy=1", r_p, r_cy); end
    @(negedge clk); #2;
    rst = 1'b1; #1;
    vectors++; if (r_p !== 48'h0 || r_pcout !== 48'h0) begin miscompares++; $display("FAIL async_rst_p: got p=%h pcout=%h want 0", r_p, r_pcout); end
    vectors++; if (r_cy !== 1'b0 || r_cyf !== 1'b0) begin miscompares++; $display("FAIL async_rst_cy: got %b/%b want 0/0", r_cy, r_cyf); end
    @(negedge clk);
    rst = 1'b0;
    opmode = 8'h09; m = 36'd7; cin = 1'b0;
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'h7 || r_cy !== 1'b0) begin miscompares++; $display("FAIL post_rst_acc: got p=%h cy=%b want p=7 cy=0", r_p, r_cy); end
  endtask

  task automatic test_add_carry();
    @(negedge clk);
    opmode = 8'h0D; m = 36'h5; c = 48'hA; cin = 1'b1; #1;
    vectors++; if (k_p !== 48'h10 || k_cy !== 1'b0) begin miscompares++; $display("FAIL add_comb: got p=%h cy=%b want p=10 cy=0", k_p, k_cy); end
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'h10 || r_pcout !== 48'h10 || r_cy !== 1'b0) begin miscompares++; $display("FAIL add_reg: got p=%h pcout=%h cy=%b want 10/10/0", r_p, r_pcout, r_cy); end
    @(negedge clk);
    c = 48'hFFFF_FFFF_FFFF; m = 36'h0; cin = 1'b1;
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'h0 || r_cy !== 1'b1 || r_cyf !== 1'b1) begin miscompares++; $display("FAIL add_cin_carry: got p=%h cy=%b cyf=%b want 0/1/1", r_p, r_cy, r_cyf); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    opmode = 8'h0C; c = 48'hFFFF_FFFF_FFFF; cin = 1'b0;
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'hFFFF_FFFF_FFFF || r_cy !== 1'b0) begin miscompares++; $display("FAIL wrap_preset: got p=%h cy=%b want ffffffffffff/0", r_p, r_cy); end
    @(negedge clk);
    opmode = 8'h09; m = 36'd1; #1;
    vectors++; if (k_p !== 48'h0 || k_cy !== 1'b1) begin miscompares++; $display("FAIL wrap_comb: got p=%h cy=%b want 0/1", k_p, k_cy); end
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'h0 || r_pcout !== 48'h0 || r_cy !== 1'b1) begin miscompares++; $display("FAIL wrap_step1: got p=%h pcout=%h cy=%b want 0/0/1", r_p, r_pcout, r_cy); end
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'h1 || r_cy !== 1'b0) begin miscompares++; $display("FAIL wrap_step2: got p=%h cy=%b want 1/0", r_p, r_cy); end
  endtask

  task automatic test_sub_borrow();
    @(negedge clk);
    opmode = 8'h0F; c = 48'h0; d = 18'h3F001; a = 18'h1; b = 18'h2; cin = 1'b0;
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'h0010_0004_0002) begin miscompares++; $display("FAIL concat: got %h want 001000040002", r_p); end
    @(negedge clk);
    opmode = 8'hFF; c = 48'd10; d = 18'h0; a = 18'h0; b = 18'd3; cin = 1'b1;
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'd6 || r_cy !== 1'b0) begin miscompares++; $display("FAIL sub_noborrow: got p=%h cy=%b want 6/0", r_p, r_cy); end
    @(negedge clk);
    opmode = 8'h8F; c = 48'd3; b = 18'd5; cin = 1'b0;
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'hFFFF_FFFF_FFFE || r_cy !== 1'b1) begin miscompares++; $display("FAIL sub_borrow: got p=%h cy=%b want fffffffffffe/1", r_p, r_cy); end
  endtask

  task automatic test_enable_indep();
    @(negedge clk);
    cep = 1'b0; cecarryin = 1'b1;
    opmode = 8'h0D; m = 36'd1; c = 48'd2; b = 18'd0; cin = 1'b0;
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'hFFFF_FFFF_FFFE || r_pcout !== 48'hFFFF_FFFF_FFFE) begin miscompares++; $display("FAIL cep_hold: got p=%h pcout=%h want fffffffffffe", r_p, r_pcout); end
    vectors++; if (r_cy !== 1'b0) begin miscompares++; $display("FAIL cy_update: got %b want 0", r_cy); end
    @(negedge clk);
    cep = 1'b1; cecarryin = 1'b0;
    c = 48'hFFFF_FFFF_FFFF;
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'h0 || r_pcout !== 48'h0) begin miscompares++; $display("FAIL cep_update: got p=%h pcout=%h want 0", r_p, r_pcout); end
    vectors++; if (r_cy !== 1'b0) begin miscompares++; $display("FAIL cy_hold: got %b want 0", r_cy); end
    @(negedge clk);
    cecarryin = 1'b1;
  endtask

  task automatic test_comb_mode();
    @(negedge clk);
    cep = 1'b0; opmode = 8'h05; pcin = 48'h1; m = 36'h2; cin = 1'b0; #1;
    vectors++; if (k_p !== 48'h3 || k_pcout !== 48'h0 || k_cy !== 1'b0) begin miscompares++; $display("FAIL comb_same_cycle: got p=%h pcout=%h cy=%b want 3/0/0", k_p, k_pcout, k_cy); end
    @(posedge clk); #1;
    vectors++; if (k_pcout !== 48'h0 || k_p !== 48'h3) begin miscompares++; $display("FAIL comb_pcout_hold: got p=%h pcout=%h want 3/0", k_p, k_pcout); end
    @(negedge clk);
    pcin = 48'hFFFF_FFFF_FFFF; m = 36'h1; #1;
    vectors++; if (k_p !== 48'h0 || k_cy !== 1'b1 || k_cyf !== 1'b1) begin miscompares++; $display("FAIL comb_carry: got p=%h cy=%b cyf=%b want 0/1/1", k_p, k_cy, k_cyf); end
    @(negedge clk);
    pcin = 48'h1; m = 36'h2; cep = 1'b1;
    @(posedge clk); #1;
    vectors++; if (k_pcout !== 48'h3 || r_p !== 48'h3) begin miscompares++; $display("FAIL comb_pcout_update: got pcout=%h reg_p=%h want 3/3", k_pcout, r_p); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    opmode = 8'h0A; cin = 1'b1; #1;
    vectors++; if (k_p !== 48'h7) begin miscompares++; $display("FAIL dbl_comb: got %h want 7", k_p); end
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'h7 || k_pcout !== 48'h7) begin miscompares++; $display("FAIL dbl_step1: got p=%h pcout=%h want 7/7", r_p, k_pcout); end
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'hF) begin miscompares++; $display("FAIL dbl_step2: got %h want f", r_p); end
    @(negedge clk);
    opmode = 8'h8A; cin = 1'b1; #1;
    vectors++; if (k_p !== 48'hFFFF_FFFF_FFFF || k_cy !== 1'b1) begin miscompares++; $display("FAIL selfsub_comb: got p=%h cy=%b want ffffffffffff/1", k_p, k_cy); end
    @(posedge clk); #1;
    vectors++; if (r_p !== 48'hFFFF_FFFF_FFFF || r_cy !== 1'b1) begin miscompares++; $display("FAIL selfsub_reg: got p=%h cy=%b want ffffffffffff/1", r_p, r_cy); end
  endtask

  initial begin
    rst = 1'b1; cep = 1'b1; cecarryin = 1'b1;
    opmode = 8'h00; m = '0; d = '0; a = '0; b = '0; c = '0; pcin = '0; cin = 1'b0;
    test_reset();
    test_add_carry();
    test_wrap();
    test_sub_borrow();
    test_enable_indep();
    test_comb_mode();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/post_adder_carryout.md
# post_adder_carryout

48-bit post-adder/subtractor with carry-out for the DSP48A1 slice. It sits after the multiplier and the carry-in select stage, which supplies its CIN. It selects the X and Z operands from OPMODE, forms Z ± (X + CIN), and holds the result in an accumulator register that feeds P, PCOUT and the P feedback path. CARRYOUT/CARRYOUTF are the far end of the carry path that starts at the carry-in mux.

## Interface
- PREG, 1, 1: P output taken from accumulator register; 0: P output combinational.
- CARRYOUTREG, 1, 1: CARRYOUT/CARRYOUTF registered; 0: combinational.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset of all registers.
- CEP  input  1  clock enable, accumulator register.
- CECARRYIN  input  1  clock enable, carry-out register.
- OPMODE  input  8  [1:0] X select, [3:2] Z select, [7] subtract; other bits ignored.
- M  input  36  multiplier product.
- D  input  18  concatenation source; only D[11:0] used.
- A  input  18  concatenation source.
- B  input  18  concatenation source.
- C  input  48  C operand.
- PCIN  input  48  cascade input.
- CIN  input  1  carry-in from the carry-in select stage.
- P  output  48  result.
- PCOUT  output  48  cascade output; always equals the accumulator register.
- CARRYOUT  output  1  carry/borrow out.
- CARRYOUTF  output  1  fabric copy of CARRYOUT; always identical to CARRYOUT.

## Operation
- X mux (OPMODE[1:0]):
  - 0 → 0
  - 1 → {12'b0, M}
  - 2 → acc
  - 3 → {D[11:0], A, B}
- Z mux (OPMODE[3:2]):
  - 0 → 0
  - 1 → PCIN
  - 2 → acc
  - 3 → C
- "acc" is the internal 48-bit accumulator register. It always exists, independent of PREG, so the P feedback path is never a combinational loop.
- Arithmetic is 49-bit unsigned on zero-extended operands:
  - OPMODE[7]=0: sum = {0,Z} + {0,X} + CIN
  - OPMODE[7]=1: sum = {0,Z} − {0,X} − CIN
- Result is sum[47:0]. Carry-out bit is sum[48]: carry for add, borrow (1 = Z < X+CIN) for subtract.
- Accumulator: on a rising CLK with CEP=1, acc ← sum[47:0]. With CEP=0, acc holds.
- Carry register: on a rising CLK with CECARRYIN=1, cyo_q ← sum[48]. With CECARRYIN=0, it holds.
- P output:
  - PREG=1: P = acc.
  - PREG=0: P = sum[47:0].
- CARRYOUT = CARRYOUTF:
  - CARRYOUTREG=1: cyo_q.
  - CARRYOUTREG=0: sum[48].
- PCOUT = acc in both PREG modes.
- Undefined OPMODE bits (6:4) have no effect.

## Timing
- Reset: RST=1 asynchronously clears acc and cyo_q to 0 without waiting for CLK. RST has priority over CEP and CECARRYIN.
- Outputs during reset: P=0 (PREG=1), PCOUT=0, CARRYOUT=CARRYOUTF=0 (CARRYOUTREG=1). Combinational outputs follow the inputs with acc=0.
- Latency from operands/OPMODE/CIN:
  - P: 1 cycle (PREG=1) or 0 cycles (PREG=0).
  - CARRYOUT: 1 cycle (CARRYOUTREG=1) or 0 cycles (CARRYOUTREG=0).
- Feedback: X or Z = acc uses the value captured at the previous enabled edge. Accumulation therefore advances one step per CEP=1 cycle.
- CEP and CECARRYIN are independent. A cycle with CEP=1 and CECARRYIN=0 updates acc but not cyo_q, and vice versa.
- Wrap-around: a 48-bit overflow wraps modulo 2^48, and the carry appears only on CARRYOUT. No saturation.
- Subtract underflow: the result wraps and the borrow bit is 1.
- RST asserted mid-accumulation: acc is 0 immediately. The first enabled edge after RST deasserts computes using acc=0.
- X=acc and Z=acc at the same time is legal: result is 2·acc+CIN, or −CIN for subtract.

## Test plan
- Reset: PREG=1, CARRYOUTREG=1. Pre-load acc, then pulse RST between clock edges → P=PCOUT=0 and CARRYOUT=0 immediately, before the next edge.
- Add with carry: OPMODE=0x0D (X=M, Z=C), M=0x5, C=0xA, CIN=1 → P=0x10 and CARRYOUT=0 one cycle later.
- Accumulate and wrap: OPMODE=0x09 (X=M, Z=acc), M=1, acc preset to 0xFFFF_FFFF_FFFF, CEP=1 → next P=0, CARRYOUT=1. Following cycle P=1, CARRYOUT=0.
- Subtract with borrow: OPMODE=0x8F (X={D,A,B}, Z=C, sub), C=3, D=A=0, B=5, CIN=0 → P=0xFFFF_FFFF_FFFE, CARRYOUT=1.
- Enable independence: CEP=0, CECARRYIN=1 while the inputs change → P/PCOUT hold the old value, CARRYOUT updates. Then swap the enables → the opposite behaviour.
- Combinational mode: PREG=0, CARRYOUTREG=0, OPMODE=0x05 (X=M, Z=PCIN), PCIN=0x1, M=0x2 → P=0x3 in the same cycle, PCOUT unchanged until the next CEP=1 edge.
